// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard, redirect and interrupt-entry sequencing for a 3-stage pipeline.
// Optional feature: define FORWARDING_EN to enable MW->DE ALU forwarding.
module pipeline_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       de_rs1,
   input  logic [4:0]       de_rs2,
   input  logic             de_use_rs1,
   input  logic             de_use_rs2,
   input  logic             de_br_taken,
   input  logic             de_is_mret,
   input  logic [4:0]       mw_rd,
   input  logic             mw_reg_wr,
   input  logic             mw_is_load,
   input  logic             ext_irq,
   input  logic             irq_en,
   output logic             fwd_a,
   output logic             fwd_b,
   output logic             stall,
   output logic             flush_de,
   output logic             flush_mw,
   output logic [1:0]       pc_sel,
   output logic             trap_take,
   output logic             irq_busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   typedef enum logic [1:0] {RUN, IRQ_DRAIN, IRQ_TRAP} state_t;
   state_t state, state_nx;
   logic hz_1, hz_2, load_use, fwd_ok, redirect, irq_go;
   assign hz_1 = de_use_rs1 & mw_reg_wr & (mw_rd != 5'd0) & (mw_rd == de_rs1);
   assign hz_2 = de_use_rs2 & mw_reg_wr & (mw_rd != 5'd0) & (mw_rd == de_rs2);
`ifdef FORWARDING_EN
   assign fwd_ok   = 1'b1;
   assign load_use = (hz_1 | hz_2) & mw_is_load;
`else
   assign fwd_ok   = 1'b0;
   assign load_use = hz_1 | hz_2;
`endif
   assign redirect = (de_br_taken | de_is_mret) & ~load_use;
   assign irq_go   = ext_irq & irq_en & ~load_use & ~redirect;
   // Outputs are forced low while reset is held, regardless of the inputs.
   always_comb begin
      state_nx  = state;
      fwd_a     = 1'b0;
      fwd_b     = 1'b0;
      stall     = 1'b0;
      flush_de  = 1'b0;
      flush_mw  = 1'b0;
      pc_sel    = 2'b00;
      trap_take = 1'b0;
      irq_busy  = 1'b0;
      if (rst) begin
         case (state)
            RUN: begin
               fwd_a    = fwd_ok & hz_1 & ~mw_is_load;
               fwd_b    = fwd_ok & hz_2 & ~mw_is_load;
               stall    = load_use;
               flush_mw = load_use;
               flush_de = redirect;
               pc_sel   = redirect ? (de_is_mret ? 2'b11 : 2'b01) : 2'b00;
               irq_busy = irq_go;
               state_nx = irq_go ? IRQ_DRAIN : RUN;
            end
            IRQ_DRAIN: begin
               trap_take = 1'b1;
               flush_mw  = 1'b1;
               stall     = 1'b1;
               irq_busy  = 1'b1;
               state_nx  = IRQ_TRAP;
            end
            default: begin
               pc_sel   = 2'b10;
               flush_de = 1'b1;
               irq_busy = 1'b1;
               state_nx = RUN;
            end
         endcase
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= RUN;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state <= state_nx;
         if (stall && state == RUN && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_de && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end
endmodule
